// File: rtl/frame_pixel_source.sv
// Raster-order frame reader: walks a ROWS x COLS frame memory and streams pixels
// with SOF/EOL/EOF markers, optional line blanking and a tail gap before frame_done_o.
module frame_pixel_source #(
    parameter int COLS    = 30,
    parameter int ROWS    = 30,
    parameter int ADDR_W  = 10,
    parameter int H_BLANK = 0,
    parameter int V_BLANK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        data_o,
    output logic              done_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(H_BLANK + V_BLANK + 3);
    localparam int HB_LAST_I = (H_BLANK > 0) ? H_BLANK - 1 : 0;
    localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(HB_LAST_I);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(V_BLANK + 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam bit HAS_HBLANK = (H_BLANK > 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_HBLANK = 3'd2,
        S_TAIL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q;
    logic [2:0]        f1_q;
    logic              done_q;
    logic [7:0]        data_q;
    logic [2:0]        flags_q;
    logic              last_col_s, last_row_s;
    logic [2:0]        flags_s;

    assign last_col_s = (col_q == COL_LAST);
    assign last_row_s = (row_q == ROW_LAST);
    // Markers belong to the pixel being read this cycle: {sof, eol, eof}
    assign flags_s = {(row_q == '0) && (col_q == '0), last_col_s, last_col_s && last_row_s};

    // Next-state and counter update logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                col_d  = '0;
                row_d  = '0;
                cnt_d  = '0;
                addr_d = '0;
                if (start_i) begin
                    state_d = S_ACTIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                cnt_d = '0;
                if (last_col_s) begin
                    col_d = '0;
                    if (last_row_s) begin
                        state_d = S_TAIL;
                    end else begin
                        row_d  = row_q + ROW_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        if (HAS_HBLANK) begin
                            state_d = S_HBLANK;
                        end else begin
                            state_d = S_ACTIVE;
                        end
                    end
                end else begin
                    col_d  = col_q + COL_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The tail includes two extra cycles so the read pipeline empties first
            S_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and two-stage read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            v1_q    <= 1'b0;
            f1_q    <= 3'b000;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            v1_q    <= (state_q == S_ACTIVE);
            f1_q    <= (state_q == S_ACTIVE) ? flags_s : 3'b000;
            done_q  <= v1_q;
            if (v1_q) begin
                data_q <= mem_data_i;
            end
            flags_q <= v1_q ? f1_q : 3'b000;
        end
    end

    assign rd_en_o      = (state_q == S_ACTIVE);
    assign addr_o       = addr_q;
    assign data_o       = data_q;
    assign done_o       = done_q;
    assign sof_o        = flags_q[2];
    assign eol_o        = flags_q[1];
    assign eof_o        = flags_q[0];
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);

endmodule
